// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
// Optional perf counters in pipeline_control: PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t SC_GO    = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t SC_HOLD  = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t SC_CLR   = '{en: 1'b0, flush: 1'b1};
  localparam stage_ctrl_t SC_FLUSH = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_control_load_use.sv
// Load-use comparator: EX load whose rd feeds an ID source.
// x0 is never a hazard since it is hardwired to zero.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  logic rd_nz;
  logic hit;

  assign rd_nz  = |ex_rd;
  assign hit    = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hazard = ex_mem_read & rd_nz & hit;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard/stall controller with memory-wait timeout FSM.
// Define PIPE_CTRL_PERF_EN to add stall/flush perf counters.
module pipeline_control
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  mem_timeout,
  output logic [1:0]            state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1
                    : $clog2(MEM_TIMEOUT + 1);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LAST =
    CW'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  state_e        st_q;
  logic [CW-1:0] wait_cnt;
  logic          lu_hz;
  logic          freeze;
  logic          sel_hold;
  logic          sel_frz;
  logic          sel_br;
  logic          sel_lu;

  stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (lu_hz)
  );

  // Release cycle of a wait (mem_ready high) is not frozen.
  assign freeze = ~mem_ready &
    ((st_q == MEM_WAIT) | ((st_q == RUN) & mem_req));

  assign sel_hold = reset | (st_q == FAULT);
  assign sel_frz  = ~sel_hold & freeze;
  assign sel_br   = ~sel_hold & ~freeze & ex_branch_taken;
  assign sel_lu   = ~sel_hold & ~freeze
                  & ~ex_branch_taken & lu_hz;

  always_comb begin
    pc_en   = 1'b1;
    ifid_c  = SC_GO;
    idex_c  = SC_GO;
    exmem_c = SC_GO;
    memwb_c = SC_GO;
    unique case (1'b1)
      sel_hold: begin
        pc_en   = 1'b0;
        ifid_c  = SC_CLR;
        idex_c  = SC_CLR;
        exmem_c = SC_CLR;
        memwb_c = SC_CLR;
      end
      sel_frz: begin
        pc_en   = 1'b0;
        ifid_c  = SC_HOLD;
        idex_c  = SC_HOLD;
        exmem_c = SC_HOLD;
        memwb_c = SC_HOLD;
      end
      sel_br: begin
        ifid_c = SC_FLUSH;
        idex_c = SC_FLUSH;
      end
      sel_lu: begin
        pc_en  = 1'b0;
        ifid_c = SC_HOLD;
        idex_c = SC_FLUSH;
      end
      default: ;
    endcase
  end

  assign ifid_en     = ifid_c.en;
  assign idex_en     = idex_c.en;
  assign exmem_en    = exmem_c.en;
  assign memwb_en    = memwb_c.en;
  assign ifid_flush  = ifid_c.flush;
  assign idex_flush  = idex_c.flush;
  assign exmem_flush = exmem_c.flush;
  assign memwb_flush = memwb_c.flush;
  assign state       = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (st_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            st_q     <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            st_q <= RUN;
          end else if (TO_EN && wait_cnt == LAST) begin
            st_q        <= FAULT;
            mem_timeout <= 1'b1;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FAULT: ;
        default: st_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (sel_frz | sel_lu)
        stall_cycles <= stall_cycles + 32'd1;
      if (sel_br)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central hazard and stall controller for the 5-stage pipeline. It drives the enable and synchronous-clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It also includes a timeout FSM that latches a fault when memory never answers.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before fault; 0 disables the timeout

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register clears, wired to the registers' synchronous reset
- mem_timeout  out  1  sticky fault flag
- state  out  2  FSM state, for debug

## Operation
- FSM states: RUN=0, MEM_WAIT=1, FAULT=2.
- Reset:
  - state=RUN, wait_cnt=0, mem_timeout=0.
  - While reset is high: all enables 0, all flushes 1.
- Outputs are combinational from the registered state and the current inputs. Priority order: reset > FAULT > memory freeze > branch flush > load-use stall > normal.
- Normal: all enables 1, all flushes 0.
- Memory freeze: state==MEM_WAIT, or state==RUN with mem_req & !mem_ready. All enables 0, all flushes 0, so the pipeline holds.
- Branch flush (ex_branch_taken, no freeze):
  - pc_en=1, ifid_flush=1, idex_flush=1.
  - Remaining enables 1.
  - Branch overrides load-use.
- Load-use stall: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - pc_en=0, ifid_en=0, idex_flush=1.
  - exmem_en=1, memwb_en=1.
- FAULT: all enables 0, all flushes 1, mem_timeout=1. Only reset exits FAULT.
- Transitions:
  - RUN→MEM_WAIT when mem_req & !mem_ready; wait_cnt←0.
  - MEM_WAIT→RUN when mem_ready. In that cycle the outputs follow the normal/branch/load-use rules, not the freeze.
  - MEM_WAIT→FAULT when mem_ready is low, MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT-1. Otherwise wait_cnt increments.
- wait_cnt width is $clog2(MEM_TIMEOUT+1), minimum 1. It never wraps; FAULT is reached first.
- A branch asserted during a freeze takes effect on the release cycle, because EX is held and the input persists.

## Timing
- Zero-latency control: outputs settle in the same cycle as the inputs, and the pipeline registers act on the next posedge.
- A load-use hazard inserts exactly one bubble.
- A taken branch costs two slots (IF, ID).
- A memory access with k wait cycles freezes the pipeline for k cycles. The access that is ready on its first cycle causes no freeze.
- FAULT is entered at the edge ending the MEM_TIMEOUT-th MEM_WAIT cycle. It is visible one cycle later as state=2 and mem_timeout=1.
- Reset asserted mid-wait: the next edge returns to RUN with the counter cleared.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs stall_cycles and flush_events, 32 bits each, reset to 0.
  - stall_cycles increments on every load-use stall or freeze cycle.
  - flush_events increments on every branch flush.
  - Both counters wrap modulo 2^32 and freeze in FAULT.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, FAULT)
  - a stage_ctrl_t struct {en, flush}
  - the default REG_ADDR_W constant
- Sub-module load_use_detect: the combinational rs1/rs2-vs-rd comparator, including the x0 exclusion.
- The FSM and output muxing stay in pipeline_control.

## Test plan
- Reset held 2 cycles → all enables 0, flushes 1, state=0. After release with idle inputs → all enables 1, flushes 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - Repeat with ex_rd=0 → no stall.
- ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_en=1; branch wins.
- mem_req=1, mem_ready low for 3 cycles then high → 3 frozen cycles (state=1 for 2 of them), then normal outputs and state=0.
- MEM_TIMEOUT=4, mem_req=1, mem_ready never → state=2 and mem_timeout=1 after 4 MEM_WAIT cycles.
  - Stays faulted with mem_ready high.
  - Reset clears it.
- PIPE_CTRL_PERF_EN: 2 load-use stalls plus a 3-cycle freeze plus 1 branch → stall_cycles=5, flush_events=1.
